// File: rtl/assoc_table.sv
// rtl/assoc_table.sv - associative key/data table with request/response port and timed dump readout
// Optional feature macro: ASSOC_TABLE_LRU_REPLACE_EN (LRU eviction on a full-table allocating miss)
module assoc_table #(
   parameter int DATA_WIDTH = 8,
   parameter int KEY_WIDTH  = 4,
   parameter int DEPTH      = 4,
   parameter int DUMP_TICKS = 50000000,
   localparam int CW = $clog2(DEPTH+1)
) (
   input  logic                  clk,
   input  logic                  async_reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            op,
   input  logic [KEY_WIDTH-1:0]  key,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  rsp_valid,
   output logic                  rsp_hit,
   output logic                  rsp_drop,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [CW-1:0]         count,
   output logic                  full,
   input  logic                  dump_start,
   output logic                  dump_busy,
   output logic                  dump_valid,
   output logic [KEY_WIDTH-1:0]  dump_key,
   output logic [DATA_WIDTH-1:0] dump_data
);
   localparam int IW = $clog2(DEPTH);
   localparam int TW = $clog2(DUMP_TICKS+1);
   localparam logic [1:0] OP_NONE = 2'd0, OP_LOAD = 2'd1, OP_INCR = 2'd2, OP_CLR = 2'd3;

   typedef enum logic {IDLE, DUMP} state_t;
   state_t state;

   logic [DEPTH-1:0]      ent_valid;
   logic [KEY_WIDTH-1:0]  ent_tag  [DEPTH];
   logic [DATA_WIDTH-1:0] ent_data [DEPTH];

   logic          acc, hit, free_any, miss_wr, alloc, drop;
   logic [IW-1:0] hit_idx, free_idx, wr_idx, dump_ptr, nxt_ptr;
   logic [CW-1:0] count_nxt;
   logic [TW-1:0] dump_tick;

   assign req_ready = (state == IDLE) && !dump_start;
   assign acc       = req_valid && req_ready;
   assign miss_wr   = acc && !hit && (op == OP_LOAD || op == OP_INCR);

   // Descending scan so the lowest matching / lowest free index wins.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (ent_valid[i] && ent_tag[i] == key) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
         if (!ent_valid[i]) begin
            free_any = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

`ifdef ASSOC_TABLE_LRU_REPLACE_EN
   // Ranks stay dense (0..count-1), so on a full table the victim is the one ranked DEPTH-1.
   logic [IW-1:0] ent_age [DEPTH];
   logic [IW-1:0] victim_idx;

   always_comb begin
      victim_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] && ent_age[i] == IW'(DEPTH-1)) victim_idx = IW'(i);
      end
   end
`endif

   always_comb begin
      alloc  = 1'b0;
      drop   = 1'b0;
      wr_idx = hit_idx;
      if (miss_wr) begin
         if (free_any) begin
            alloc  = 1'b1;
            wr_idx = free_idx;
         end else begin
`ifdef ASSOC_TABLE_LRU_REPLACE_EN
            alloc  = 1'b1;
            wr_idx = victim_idx;
`else
            drop   = 1'b1;
`endif
         end
      end
   end

   always_comb begin
      count_nxt = count;
      if (acc && hit && op == OP_CLR)   count_nxt = count - CW'(1);
      else if (miss_wr && free_any)     count_nxt = count + CW'(1);
   end

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         ent_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_tag[i]  <= '0;
            ent_data[i] <= '0;
         end
         count     <= '0;
         full      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rsp_drop  <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= acc;
         rsp_hit   <= acc && hit;
         rsp_drop  <= drop;
         rsp_data  <= (acc && hit) ? ent_data[hit_idx] : '0;
         if (acc && hit) begin
            case (op)
               OP_NONE: ;
               OP_LOAD: ent_data[hit_idx] <= data_in;
               OP_INCR: ent_data[hit_idx] <= ent_data[hit_idx] + DATA_WIDTH'(1);
               OP_CLR: begin
                  ent_valid[hit_idx] <= 1'b0;
                  ent_tag[hit_idx]   <= '0;
                  ent_data[hit_idx]  <= '0;
               end
            endcase
         end else if (alloc) begin
            ent_valid[wr_idx] <= 1'b1;
            ent_tag[wr_idx]   <= key;
            ent_data[wr_idx]  <= data_in;
         end
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
      end
   end

`ifdef ASSOC_TABLE_LRU_REPLACE_EN
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         for (int i = 0; i < DEPTH; i++) ent_age[i] <= '0;
      end else if (acc && hit && op == OP_CLR) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (IW'(i) == hit_idx)
               ent_age[i] <= '0;
            else if (ent_valid[i] && ent_age[i] > ent_age[hit_idx])
               ent_age[i] <= ent_age[i] - IW'(1);
         end
      end else if (acc && (hit || alloc)) begin
         // A fresh slot ages every live entry; a hit or eviction ages only the younger ones.
         for (int i = 0; i < DEPTH; i++) begin
            if (IW'(i) == wr_idx)
               ent_age[i] <= '0;
            else if (ent_valid[i] && ((alloc && free_any) || ent_age[i] < ent_age[wr_idx]))
               ent_age[i] <= ent_age[i] + IW'(1);
         end
      end
   end
`endif

   assign nxt_ptr = (state == IDLE) ? '0 : dump_ptr + IW'(1);

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         state      <= IDLE;
         dump_ptr   <= '0;
         dump_tick  <= '0;
         dump_busy  <= 1'b0;
         dump_valid <= 1'b0;
         dump_key   <= '0;
         dump_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (dump_start) begin
                  state      <= DUMP;
                  dump_busy  <= 1'b1;
                  dump_ptr   <= nxt_ptr;
                  dump_tick  <= TW'(1);
                  dump_valid <= ent_valid[nxt_ptr];
                  dump_key   <= ent_valid[nxt_ptr] ? ent_tag[nxt_ptr]  : '0;
                  dump_data  <= ent_valid[nxt_ptr] ? ent_data[nxt_ptr] : '0;
               end
            end
            DUMP: begin
               if (dump_valid && dump_tick != TW'(DUMP_TICKS)) begin
                  dump_tick <= dump_tick + TW'(1);
               end else if (dump_ptr == IW'(DEPTH-1)) begin
                  state      <= IDLE;
                  dump_busy  <= 1'b0;
                  dump_tick  <= '0;
                  dump_valid <= 1'b0;
                  dump_key   <= '0;
                  dump_data  <= '0;
               end else begin
                  dump_ptr   <= nxt_ptr;
                  dump_tick  <= TW'(1);
                  dump_valid <= ent_valid[nxt_ptr];
                  dump_key   <= ent_valid[nxt_ptr] ? ent_tag[nxt_ptr]  : '0;
                  dump_data  <= ent_valid[nxt_ptr] ? ent_data[nxt_ptr] : '0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_assoc_table.sv
// tb/tb_assoc_table.sv - randomized self-checking bench for assoc_table against a slot-level model
module tb_assoc_table;
   localparam int DW    = 8;
   localparam int KW    = 4;
   localparam int DEPTH = 4;
   localparam int TICKS = 3;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          async_reset, req_valid, req_ready, rsp_valid, rsp_hit, rsp_drop, full;
   logic          dump_start, dump_busy, dump_valid;
   logic [1:0]    op;
   logic [KW-1:0] key, dump_key;
   logic [DW-1:0] data_in, rsp_data, dump_data;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   assoc_table #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .DEPTH(DEPTH), .DUMP_TICKS(TICKS)) dut (
      .clk(clk), .async_reset(async_reset), .req_valid(req_valid), .req_ready(req_ready),
      .op(op), .key(key), .data_in(data_in), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
      .rsp_drop(rsp_drop), .rsp_data(rsp_data), .count(count), .full(full),
      .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
      .dump_key(dump_key), .dump_data(dump_data));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: per-slot contents plus a recency list of slot numbers, most recent first.
   bit            m_valid [DEPTH];
   logic [KW-1:0] m_key   [DEPTH];
   logic [DW-1:0] m_data  [DEPTH];
   int            lru[$];

   typedef struct {bit v; logic [KW-1:0] k; logic [DW-1:0] d;} dent_t;

   function automatic void lru_remove(input int s);
      for (int i = 0; i < lru.size(); i++) if (lru[i] == s) begin lru.delete(i); break; end
   endfunction

   function automatic void lru_touch(input int s);
      lru_remove(s);
      lru.push_front(s);
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_key[i] = '0; m_data[i] = '0; end
      lru.delete();
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) if (m_valid[i]) c++;
      return c;
   endfunction

   task automatic model_req(input logic [1:0] o, input logic [KW-1:0] k, input logic [DW-1:0] d,
                            output bit h, output bit dr, output logic [DW-1:0] rd);
      int s, f;
      s = -1; f = -1;
      for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_key[i] == k) s = i;
      for (int i = DEPTH-1; i >= 0; i--) if (!m_valid[i]) f = i;
      h = (s >= 0); dr = 0; rd = h ? m_data[s] : '0;
      if (h) begin
         if (o == 2'd1) m_data[s] = d;
         if (o == 2'd2) m_data[s] = m_data[s] + 8'd1;
         if (o == 2'd3) begin
            m_valid[s] = 0; m_key[s] = '0; m_data[s] = '0;
            lru_remove(s);
         end else lru_touch(s);
      end else if (o == 2'd1 || o == 2'd2) begin
`ifdef ASSOC_TABLE_LRU_REPLACE_EN
         if (f < 0) f = lru[lru.size()-1];
`endif
         if (f >= 0) begin
            m_valid[f] = 1; m_key[f] = k; m_data[f] = d;
            lru_touch(f);
         end else dr = 1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  32'(req_ready),  32'd1);
      check({tag, "_rspv"},   32'(rsp_valid),  32'd0);
      check({tag, "_hit"},    32'(rsp_hit),    32'd0);
      check({tag, "_drop"},   32'(rsp_drop),   32'd0);
      check({tag, "_rdata"},  32'(rsp_data),   32'd0);
      check({tag, "_count"},  32'(count),      32'd0);
      check({tag, "_full"},   32'(full),       32'd0);
      check({tag, "_busy"},   32'(dump_busy),  32'd0);
      check({tag, "_dvalid"}, 32'(dump_valid), 32'd0);
      check({tag, "_dkey"},   32'(dump_key),   32'd0);
      check({tag, "_ddata"},  32'(dump_data),  32'd0);
   endtask

   task automatic do_reset();
      async_reset = 1; req_valid = 0; dump_start = 0; op = '0; key = '0; data_in = '0;
      #1;
      check_reset_outputs("reset");
      model_clear();
      @(negedge clk);
      async_reset = 0;
   endtask

   // Drive one cycle of request inputs at a falling edge, check the response at the next one.
   task automatic step(input bit v, input logic [1:0] o, input logic [KW-1:0] k, input logic [DW-1:0] d);
      bit eh, ed;
      logic [DW-1:0] erd;
      eh = 0; ed = 0; erd = '0;
      req_valid = v; op = o; key = k; data_in = d;
      if (v) model_req(o, k, d, eh, ed, erd);
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'(v));
      check("rsp_hit",   32'(rsp_hit),   32'(eh));
      check("rsp_drop",  32'(rsp_drop),  32'(ed));
      check("rsp_data",  32'(rsp_data),  32'(erd));
      check("count",     32'(count),     32'(model_count()));
      check("full",      32'(full),      32'(model_count() == DEPTH));
      req_valid = 0;
   endtask

   // abort_at > 0 asserts reset right after that dump cycle has been checked.
   task automatic run_dump(input int abort_at);
      dent_t exp_q[$];
      dent_t e;
      int    c0;
      for (int i = 0; i < DEPTH; i++) begin
         if (m_valid[i]) begin
            e.v = 1; e.k = m_key[i]; e.d = m_data[i];
            for (int t = 0; t < TICKS; t++) exp_q.push_back(e);
         end else begin
            e.v = 0; e.k = '0; e.d = '0;
            exp_q.push_back(e);
         end
      end
      c0 = model_count();
      dump_start = 1; req_valid = 1; op = 2'd1;
      key = KW'($urandom_range(0, 15)); data_in = DW'($urandom);
      #1;
      check("ready_vs_start", 32'(req_ready), 32'd0);
      for (int c = 0; c < exp_q.size(); c++) begin
         @(negedge clk);
         if (c == 1) dump_start = 0;
         check("dump_busy",  32'(dump_busy),  32'd1);
         check("dump_valid", 32'(dump_valid), 32'(exp_q[c].v));
         check("dump_key",   32'(dump_key),   32'(exp_q[c].k));
         check("dump_data",  32'(dump_data),  32'(exp_q[c].d));
         check("dump_ready", 32'(req_ready),  32'd0);
         check("dump_norsp", 32'(rsp_valid),  32'd0);
         if (abort_at == c + 1) begin
            dump_start = 0; req_valid = 0;
            async_reset = 1;
            #1;
            check_reset_outputs("abort");
            model_clear();
            @(negedge clk);
            async_reset = 0;
            return;
         end
      end
      @(negedge clk);
      check("dump_end_busy",  32'(dump_busy),  32'd0);
      check("dump_end_valid", 32'(dump_valid), 32'd0);
      check("dump_end_rsp",   32'(rsp_valid),  32'd0);
      check("dump_end_count", 32'(count),      32'(c0));
      req_valid = 0;
   endtask

   initial begin
      do_reset();

      step(1, 2'd1, 4'd3, 8'h10);
      step(1, 2'd0, 4'd3, 8'h00);
      check("lookup3_const", 32'(rsp_data), 32'h10);

      step(1, 2'd1, 4'd5, 8'hFF);
      step(1, 2'd2, 4'd5, 8'h00);
      step(1, 2'd2, 4'd5, 8'h00);
      check("incr_wrap_const", 32'(rsp_data), 32'h00);
      step(1, 2'd0, 4'd5, 8'h00);
      check("after_wrap_const", 32'(rsp_data), 32'h01);

      do_reset();
      for (int k = 1; k <= 4; k++) step(1, 2'd1, KW'(k), DW'(8'h20 + k));
`ifdef ASSOC_TABLE_LRU_REPLACE_EN
      for (int k = 2; k <= 4; k++) step(1, 2'd0, KW'(k), 8'h00);
`endif
      step(1, 2'd1, 4'd7, 8'h77);
      step(1, 2'd0, 4'd7, 8'h00);
      step(1, 2'd0, 4'd1, 8'h00);
      step(1, 2'd3, 4'd2, 8'h00);
      step(1, 2'd1, 4'd9, 8'h99);
      run_dump(0);

      do_reset();
      step(1, 2'd1, 4'd1, 8'hA1);
      step(1, 2'd1, 4'd2, 8'hA2);
      step(1, 2'd1, 4'd3, 8'hA3);
      step(1, 2'd3, 4'd2, 8'h00);
      run_dump(0);
      run_dump(4);
      step(1, 2'd0, 4'd1, 8'h00);

      for (int n = 0; n < 400; n++) begin
         logic [1:0] o;
         o = 2'($urandom_range(0, 3));
         if (o == 2'd3 && $urandom_range(0, 1) == 0) o = 2'd1;
         step($urandom_range(0, 3) != 0, o, KW'($urandom_range(0, 7)), DW'($urandom));
         if (n % 80 == 79) run_dump(0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
